// File: rtl/axi_wr_arbmux3.sv
// Round-robin arbiter and AW/W/B multiplexer granting one of three write managers the single AXI write port.
// Optional watchdog: define WR_ARB_TIMEOUT_EN to add the TIMEOUT_CYC busy-cycle limit and the err_to pulse.
module axi_wr_arbmux3 #(
   parameter int AWD = 32,
   parameter int DWD = 32,
   parameter int IDW = 4
`ifdef WR_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 1024
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       req,
   output logic [2:0]       gnt,
   output logic [2:0]       sel,
   input  logic [2:0]       m_awvalid,
   output logic [2:0]       m_awready,
   input  logic [3*IDW-1:0] m_awid,
   input  logic [3*AWD-1:0] m_awaddr,
   input  logic [3*6-1:0]   m_awatop,
   input  logic [2:0]       m_wvalid,
   output logic [2:0]       m_wready,
   input  logic [3*DWD-1:0] m_wdata,
   input  logic [2:0]       m_wlast,
   output logic [2:0]       m_bvalid,
   input  logic [2:0]       m_bready,
   output logic [IDW-1:0]   m_bid,
   output logic             m_bcomp,
   output logic             awvalid,
   input  logic             awready,
   output logic [IDW-1:0]   awid,
   output logic [AWD-1:0]   awaddr,
   output logic [5:0]       awatop,
   output logic             wvalid,
   input  logic             wready,
   output logic [DWD-1:0]   wdata,
   output logic             wlast,
   input  logic             bvalid,
   output logic             bready,
   input  logic [IDW-1:0]   bid,
   input  logic             bcomp,
   output logic             finish
`ifdef WR_ARB_TIMEOUT_EN
   ,
   output logic             err_to
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, REL} state_t;

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_sel;
   logic [1:0] r_last;
   logic [1:0] w_pickIdx;
   logic [2:0] w_pick;
   logic       w_bHs;
   logic       w_release;

   // Search order starts just past the previous owner and wraps around.
   always_comb begin
      w_pickIdx = 2'd0;
      case (r_last)
         2'd0: begin
            if (req[1])      w_pickIdx = 2'd1;
            else if (req[2]) w_pickIdx = 2'd2;
            else             w_pickIdx = 2'd0;
         end
         2'd1: begin
            if (req[2])      w_pickIdx = 2'd2;
            else if (req[0]) w_pickIdx = 2'd0;
            else             w_pickIdx = 2'd1;
         end
         default: begin
            if (req[0])      w_pickIdx = 2'd0;
            else if (req[1]) w_pickIdx = 2'd1;
            else             w_pickIdx = 2'd2;
         end
      endcase
   end

   assign w_pick = (|req) ? (3'b001 << w_pickIdx) : 3'b000;
   assign w_bHs  = (r_state == BUSY) & bvalid & bready;

`ifdef WR_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC - 1);

   logic [15:0] r_cnt;
   logic        r_err;
   logic        w_timeout;

   assign w_timeout = (r_state == BUSY) && (r_cnt == TO_LIM);
   assign w_release = w_bHs | w_timeout;
   assign err_to    = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 16'd0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_timeout & ~w_bHs;
         if (r_state == BUSY) r_cnt <= r_cnt + 16'd1;
         else                 r_cnt <= 16'd0;
      end
   end
`else
   assign w_release = w_bHs;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (|req) w_next = BUSY;
         BUSY:    if (w_release) w_next = REL;
         REL:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Owner register; cleared on release so gnt drops during the REL cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel  <= 3'b000;
         r_last <= 2'd2;
      end else if (r_state == IDLE && (|req)) begin
         r_sel  <= w_pick;
         r_last <= w_pickIdx;
      end else if (r_state == BUSY && w_release) begin
         r_sel  <= 3'b000;
      end
   end

   always_comb begin
      gnt    = r_sel;
      sel    = r_sel;
      finish = (r_state == REL);
   end

   // r_sel is only non-zero in BUSY, so gating by it isolates every non-owner.
   always_comb begin
      awvalid   = |(m_awvalid & r_sel);
      wvalid    = |(m_wvalid & r_sel);
      wlast     = |(m_wlast & r_sel);
      bready    = |(m_bready & r_sel);
      m_awready = {3{awready}} & r_sel;
      m_wready  = {3{wready}} & r_sel;
      m_bvalid  = {3{bvalid}} & r_sel;
      awid      = '0;
      awaddr    = '0;
      awatop    = '0;
      wdata     = '0;
      for (int i = 0; i < 3; i++) begin
         if (r_sel[i]) begin
            awid   = m_awid[i*IDW +: IDW];
            awaddr = m_awaddr[i*AWD +: AWD];
            awatop = m_awatop[i*6 +: 6];
            wdata  = m_wdata[i*DWD +: DWD];
         end
      end
   end

   assign m_bid   = bid;
   assign m_bcomp = bcomp;

endmodule
